async_fifo_rd_packer: RTL and testbench
=======================================

Name: async_fifo_rd_packer

Overview:
Read-side consumer of async_fifo, in the read clock domain. It drains the FIFO read port (rempty/rinc/rdata) and packs consecutive DATA_WIDTH entries into one PACK*DATA_WIDTH word. The packed word is presented on a valid/ready stream to the downstream datapath. A flush input forces out a partially filled word with a lane-keep mask.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (must match async_fifo DATA_WIDTH)
PACK, 4, entries per output word (power of two, 2..8)
CNT_WIDTH, 16, width of emitted-word counter

Ports:
rclk  input  1  read-domain clock (same clock as async_fifo read side)
rrst  input  1  synchronous active-high reset
rempty  input  1  FIFO empty flag from async_fifo
rdata  input  DATA_WIDTH  FIFO read data; valid whenever rempty=0 (head entry, combinational)
rinc  output  1  pop request to async_fifo; entry consumed on rclk edge when rinc=1
flush  input  1  single-cycle request to emit the partial word
out_data  output  PACK*DATA_WIDTH  packed word; lane 0 = oldest entry in bits [DATA_WIDTH-1:0]
out_keep  output  PACK  per-lane valid mask
out_valid  output  1  out_data/out_keep valid
out_ready  input  1  downstream accepts when out_valid&&out_ready at rclk edge
words_out  output  CNT_WIDTH  count of words accepted downstream, wraps at 2^CNT_WIDTH

Behaviour:
- One clock (rclk); reset synchronous, active-high (rrst). All state updates on rising rclk only.
- Reset (including mid-word): out_valid=0, out_data=0, out_keep=0, words_out=0, lane count cnt=0, accumulator cleared, flush_pend=0. Partially packed entries are discarded. rinc=0 while rrst=1.
- Output slot free: out_free = !out_valid || out_ready.
- Pop: rinc = !rrst && !rempty && (cnt < PACK). Never asserted while rempty=1, so no underflow is possible.
- On pop, rdata is written to accumulator lane cnt and cnt increments.
- Word completion, when the pop fills lane PACK-1:
  - If out_free: next edge loads out_data with the full word, out_keep = all ones, out_valid=1, cnt=0.
  - Else: cnt=PACK and the full word is held. No pops occur until out_free, then it transfers to the output on that edge and cnt=0.
- Throughput: one entry per cycle sustained with out_ready=1. No bubble between words.
- Latency: the last lane popped at edge N appears on out_valid after edge N (visible in cycle N+1).
- Flush:
  - flush=1 sets flush_pend; further flush pulses while pending are absorbed.
  - Emission happens when out_free and the effective count (cnt, plus 1 if popping this cycle) is in 1..PACK.
  - Emitted word: out_keep bit i = 1 for i < count; unused lanes are driven 0.
  - On emission: cnt=0, flush_pend=0, accumulator cleared.
  - Flush with effective count 0 emits nothing and clears flush_pend.
  - If a full word completes in the same cycle as flush, the full word is emitted (keep all ones) and flush_pend clears.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_keep are held. out_valid drops only after acceptance with no new word ready.
- words_out increments on each out_valid&&out_ready edge and wraps to 0.
- rempty rising mid-word: packing pauses with cnt held and resumes when entries arrive. There is no timeout; only flush releases a partial word.

Test Plan:
- Reset, FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 -> rinc high 4 consecutive cycles, then out_data=0x44332211, out_keep=0xF, out_valid for 1 cycle, words_out=1.
- 16 entries 0x00..0x0F streamed, out_ready=1 -> 4 back-to-back words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with no idle cycle; rinc high 16 consecutive cycles.
- out_ready=0 with 12 entries available -> first word held stable, second word held in accumulator (cnt=4), rinc=0 with rempty=0. Raising out_ready drains both words in order; third word follows.
- 3 entries 0xA1,0xA2,0xA3, FIFO then empty, flush pulse -> out_data=0x00A3A2A1, out_keep=0x7. Flush with nothing packed -> no out_valid.
- Reset asserted after 2 of 4 entries popped, then entries 0x55..0x58 -> first output 0x58575655, keep 0xF; no pre-reset data appears.
- Flush in the same cycle as the 4th pop -> one word with keep=0xF, no extra empty word. Drive words_out past 0xFFFF -> wraps to 0x0000.

Source files
------------

// File: rtl/async_fifo_rd_packer.sv
// async_fifo_rd_packer
// Read-domain consumer of async_fifo. Pops FIFO entries one per cycle and
// packs PACK consecutive entries into one wide word, lane 0 holding the
// oldest entry. Packed words leave on a valid/ready stream. A flush request
// releases a partially filled word together with a lane-keep mask.
module async_fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       rempty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rinc,
    input  logic                       flush,
    output logic [PACK*DATA_WIDTH-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_WIDTH-1:0]       words_out
);

    // Lane counter must reach PACK itself (a full word parked behind a
    // stalled output), so it gets one bit more than a lane index.
    localparam int CW     = $clog2(PACK) + 1;
    localparam int WORD_W = PACK * DATA_WIDTH;
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK);

    logic [WORD_W-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              flush_pend;

    logic              out_free;
    logic              pop;
    logic              flush_req;
    logic              word_full;
    logic              emit;
    logic [CW-1:0]     cnt_eff;
    logic [CW-1:0]     cnt_nxt;
    logic              flush_pend_nxt;
    logic [WORD_W-1:0] acc_written;
    logic [WORD_W-1:0] acc_nxt;
    logic [WORD_W-1:0] emit_word;
    logic [PACK-1:0]   keep_mask;

    // The output register can take a new word when it is empty or is being drained this edge.
    always_comb begin
        out_free = !out_valid || out_ready;
        pop      = !rrst && !rempty && (cnt < CNT_FULL);
        rinc     = pop;
    end

    // Merge the popped entry into its lane and work out the effective lane count and keep mask.
    always_comb begin
        acc_written = acc;
        for (int i = 0; i < PACK; i++) begin
            if (pop && (cnt == CW'(i))) begin
                acc_written[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
        end
        cnt_eff = cnt + CW'(pop);
        keep_mask = '0;
        emit_word = '0;
        for (int i = 0; i < PACK; i++) begin
            keep_mask[i] = (CW'(i) < cnt_eff);
            if (keep_mask[i]) begin
                emit_word[i*DATA_WIDTH +: DATA_WIDTH] = acc_written[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Decide whether a word leaves this edge; a completed word always wins over a pending flush.
    always_comb begin
        flush_req      = flush || flush_pend;
        word_full      = (cnt_eff == CNT_FULL);
        emit           = 1'b0;
        cnt_nxt        = cnt_eff;
        acc_nxt        = acc_written;
        flush_pend_nxt = flush_req;
        if (word_full) begin
            if (out_free) begin
                emit           = 1'b1;
                cnt_nxt        = '0;
                acc_nxt        = '0;
                flush_pend_nxt = 1'b0;
            end
        end else if (flush_req) begin
            if (cnt_eff == '0) begin
                flush_pend_nxt = 1'b0;
            end else if (out_free) begin
                emit           = 1'b1;
                cnt_nxt        = '0;
                acc_nxt        = '0;
                flush_pend_nxt = 1'b0;
            end
        end
    end

    // Accumulator, lane count and pending-flush state; reset discards any partial word.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Output register: load on emit, hold while stalled, drop valid once accepted with nothing new.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (emit) begin
            out_data  <= emit_word;
            out_keep  <= keep_mask;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count words accepted downstream; wraps naturally at the counter width.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            words_out <= '0;
        end else if (out_valid && out_ready) begin
            words_out <= words_out + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// tb_async_fifo_rd_packer
// Directed bench for the FIFO read-side packer. A small array stands in for
// async_fifo's read port: head entry shown combinationally, popped on rinc.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_async_fifo_rd_packer;

    localparam int DW  = 8;
    localparam int PK  = 4;
    localparam int CWD = 16;

    logic              rclk;
    logic              rrst;
    logic              rempty;
    logic [DW-1:0]     rdata;
    logic              rinc;
    logic              flush;
    logic [PK*DW-1:0]  out_data;
    logic [PK-1:0]     out_keep;
    logic              out_valid;
    logic              out_ready;
    logic [CWD-1:0]    words_out;

    logic [DW-1:0]     fifo_mem [0:63];
    logic [31:0]       wr_ptr = '0;
    logic [31:0]       rd_ptr = '0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] word_tbl [0:3];

    async_fifo_rd_packer #(
        .DATA_WIDTH(DW),
        .PACK(PK),
        .CNT_WIDTH(CWD)
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .rempty(rempty),
        .rdata(rdata),
        .rinc(rinc),
        .flush(flush),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .words_out(words_out)
    );

    // Free-running read clock, period 10.
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO model: head entry visible whenever not empty.
    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = fifo_mem[rd_ptr[5:0]];

    // FIFO model pop on the packer's request.
    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 32'd1;
    end

    // Push one entry into the FIFO model.
    task applyStimulus(input logic [DW-1:0] entry);
        fifo_mem[wr_ptr[5:0]] = entry;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    // Count one comparison and report it if it does not match.
    task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        word_tbl[0] = 32'h03020100;
        word_tbl[1] = 32'h07060504;
        word_tbl[2] = 32'h0B0A0908;
        word_tbl[3] = 32'h0F0E0D0C;

        rrst      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state; entries present but no pop while in reset.
        @(negedge rclk);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        @(negedge rclk);
        #1;
        $display("[TB] reset and first word");
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_keep", out_keep, 0);
        checkOutput("rst_words", words_out, 0);
        checkOutput("rst_rinc", rinc, 0);

        // First word: four pops then one valid cycle.
        @(negedge rclk);
        rrst = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            #1;
            if (k < 4) checkOutput("w1_rinc", rinc, 1);
            if (k == 4) begin
                checkOutput("w1_valid", out_valid, 1);
                checkOutput("w1_data", out_data, 32'h44332211);
                checkOutput("w1_keep", out_keep, 4'hF);
                checkOutput("w1_rinc_idle", rinc, 0);
            end
            if (k == 5) begin
                checkOutput("w1_valid_drop", out_valid, 0);
                checkOutput("w1_words", words_out, 1);
            end
            @(negedge rclk);
        end

        // Sixteen entries streamed with the output always ready.
        $display("[TB] streaming 16 entries");
        for (int k = 0; k <= 17; k++) begin
            if (k == 0) begin
                for (int e = 0; e < 16; e++) applyStimulus(8'(e));
            end
            #1;
            checkOutput("s_rinc", rinc, (k < 16) ? 1 : 0);
            if (k >= 4 && k <= 17) checkOutput("s_valid", out_valid, (k % 4 == 0 && k <= 16) ? 1 : 0);
            if (k >= 4 && k <= 16 && (k % 4 == 0)) begin
                checkOutput("s_data", out_data, word_tbl[k/4 - 1]);
                checkOutput("s_keep", out_keep, 4'hF);
            end
            if (k == 17) checkOutput("s_words", words_out, 5);
            @(negedge rclk);
        end

        // Backpressure: one word at the output, one parked in the accumulator.
        $display("[TB] backpressure");
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) begin
                out_ready = 1'b0;
                for (int e = 0; e < 12; e++) applyStimulus(8'(8'h20 + e));
            end
            if (k == 10) out_ready = 1'b1;
            #1;
            if (k == 4 || k == 10) begin
                checkOutput("bp_hold_valid", out_valid, 1);
                checkOutput("bp_hold_data", out_data, 32'h23222120);
                checkOutput("bp_hold_keep", out_keep, 4'hF);
            end
            if (k == 8 || k == 10) begin
                checkOutput("bp_rinc_stall", rinc, 0);
                checkOutput("bp_not_empty", rempty, 0);
            end
            if (k == 11) begin
                checkOutput("bp_w2_valid", out_valid, 1);
                checkOutput("bp_w2_data", out_data, 32'h27262524);
            end
            if (k == 12) begin
                checkOutput("bp_gap_valid", out_valid, 0);
                checkOutput("bp_resume_rinc", rinc, 1);
            end
            if (k == 15) begin
                checkOutput("bp_w3_valid", out_valid, 1);
                checkOutput("bp_w3_data", out_data, 32'h2B2A2928);
            end
            if (k == 16) checkOutput("bp_words", words_out, 8);
            @(negedge rclk);
        end

        // Partial word released by flush, then a flush with nothing packed.
        $display("[TB] flush");
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin
                applyStimulus(8'hA1);
                applyStimulus(8'hA2);
                applyStimulus(8'hA3);
            end
            flush = (k == 5 || k == 7);
            #1;
            if (k == 5) begin
                checkOutput("fl_wait_valid", out_valid, 0);
                checkOutput("fl_wait_rinc", rinc, 0);
            end
            if (k == 6) begin
                checkOutput("fl_valid", out_valid, 1);
                checkOutput("fl_data", out_data, 32'h00A3A2A1);
                checkOutput("fl_keep", out_keep, 4'h7);
            end
            if (k == 8 || k == 9) checkOutput("fl_empty_valid", out_valid, 0);
            if (k == 9) checkOutput("fl_words", words_out, 9);
            @(negedge rclk);
        end

        // Reset after two pops discards the partial word.
        $display("[TB] reset mid-word");
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) begin
                applyStimulus(8'hEE);
                applyStimulus(8'hEF);
            end
            if (k == 2) begin
                rrst = 1'b1;
                for (int e = 0; e < 4; e++) applyStimulus(8'(8'h55 + e));
            end
            if (k == 3) rrst = 1'b0;
            #1;
            if (k == 2) checkOutput("mr_rinc_rst", rinc, 0);
            if (k == 3) begin
                checkOutput("mr_valid", out_valid, 0);
                checkOutput("mr_words", words_out, 0);
            end
            if (k == 6) checkOutput("mr_no_early", out_valid, 0);
            if (k == 7) begin
                checkOutput("mr_w_valid", out_valid, 1);
                checkOutput("mr_w_data", out_data, 32'h58575655);
                checkOutput("mr_w_keep", out_keep, 4'hF);
            end
            if (k == 8) checkOutput("mr_words_after", words_out, 1);
            @(negedge rclk);
        end

        // Flush coinciding with the fourth pop yields one full word only.
        $display("[TB] flush with full word");
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) begin
                for (int e = 0; e < 4; e++) applyStimulus(8'(8'h61 + e));
            end
            flush = (k == 3);
            #1;
            if (k == 4) begin
                checkOutput("ff_valid", out_valid, 1);
                checkOutput("ff_data", out_data, 32'h64636261);
                checkOutput("ff_keep", out_keep, 4'hF);
            end
            if (k == 5 || k == 6) checkOutput("ff_no_extra", out_valid, 0);
            if (k == 6) checkOutput("ff_words", words_out, 2);
            @(negedge rclk);
        end

        // Single-lane flushed words every cycle to push words_out around its wrap.
        $display("[TB] counter wrap");
        for (int k = 0; k <= 65535; k++) begin
            if (k < 65533) begin
                applyStimulus(8'(k));
                flush = 1'b1;
            end else begin
                flush = 1'b0;
            end
            #1;
            if (k == 5) begin
                checkOutput("wr_1lane_valid", out_valid, 1);
                checkOutput("wr_1lane_data", out_data, 32'h00000004);
                checkOutput("wr_1lane_keep", out_keep, 4'h1);
                checkOutput("wr_words_early", words_out, 6);
            end
            if (k == 65535) begin
                checkOutput("wr_top", words_out, 16'hFFFF);
                checkOutput("wr_top_valid", out_valid, 0);
            end
            @(negedge rclk);
        end
        for (int k = 0; k <= 2; k++) begin
            if (k == 0) begin
                applyStimulus(8'h7E);
                flush = 1'b1;
            end else begin
                flush = 1'b0;
            end
            #1;
            if (k == 1) begin
                checkOutput("wr_last_data", out_data, 32'h0000007E);
                checkOutput("wr_last_keep", out_keep, 4'h1);
            end
            if (k == 2) checkOutput("wr_wrapped", words_out, 0);
            @(negedge rclk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
